tri_edge_sequencer: RTL

- Wireframe triangle front end for the line rasteriser.
- Accepts one triangle (three screen-space vertices plus colour) over a valid/ready handshake.
- Initiates three consecutive line jobs (v0→v1, v1→v2, v2→v0) on the line drawer's Reset/Start/Done interface. It is the initiator side of that protocol.
- Forwards the drawer's DrawX/DrawY as a pixel-write stream to the frame-buffer writer.

---
 rtl/render_pkg.sv | 27 ++
 rtl/tri_signed_area.sv | 46 ++++
 rtl/tri_edge_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared types for the wireframe triangle front end.
// BACKFACE_CULL_EN adds the AREA state used by the back-face culling path.
package render_pkg;

    localparam int COORD_W = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } vertex_t;

    typedef logic [1:0] edge_idx_t;

    localparam edge_idx_t LAST_EDGE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
`ifdef BACKFACE_CULL_EN
        S_AREA,
`endif
        S_LOAD,
        S_RUN,
        S_RELEASE,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/tri_signed_area.sv
// Registered signed triangle area (2D cross product), present only when
// BACKFACE_CULL_EN is defined.
`ifdef BACKFACE_CULL_EN
module tri_signed_area
    import render_pkg::*;
#(
    parameter int AREA_W = 2 * COORD_W + 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     en_i,
    input  logic [2*COORD_W-1:0]     p0_i,
    input  logic [2*COORD_W-1:0]     p1_i,
    input  logic [2*COORD_W-1:0]     p2_i,
    output logic signed [AREA_W-1:0] area_o
);

    vertex_t v0, v1, v2;
    logic signed [AREA_W-1:0] dx1, dy1, dx2, dy2;
    logic signed [AREA_W-1:0] area_d, area_q;

    assign v0 = vertex_t'(p0_i);
    assign v1 = vertex_t'(p1_i);
    assign v2 = vertex_t'(p2_i);

    // Coordinates are unsigned; zero-extend before subtracting so the
    // differences wrap correctly into the signed AREA_W range.
    assign dx1 = AREA_W'(v1.x) - AREA_W'(v0.x);
    assign dy1 = AREA_W'(v1.y) - AREA_W'(v0.y);
    assign dx2 = AREA_W'(v2.x) - AREA_W'(v0.x);
    assign dy2 = AREA_W'(v2.y) - AREA_W'(v0.y);

    assign area_d = dx1 * dy2 - dy1 * dx2;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            area_q <= '0;
        end else if (en_i) begin
            area_q <= area_d;
        end
    end

    assign area_o = area_q;

endmodule
`endif

// File: rtl/tri_edge_sequencer.sv
// Wireframe triangle front end: issues three line-drawer jobs per triangle and
// forwards pixels. Define BACKFACE_CULL_EN to drop triangles with area <= 0.
module tri_edge_sequencer
    import render_pkg::*;
#(
    parameter int COORD_W = render_pkg::COORD_W,
    parameter int COLOR_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] v0x,
    input  logic [COORD_W-1:0] v0y,
    input  logic [COORD_W-1:0] v1x,
    input  logic [COORD_W-1:0] v1y,
    input  logic [COORD_W-1:0] v2x,
    input  logic [COORD_W-1:0] v2y,
    input  logic [COLOR_W-1:0] tri_color,
    output logic               tri_done,
    output logic               tri_culled,
    output logic               line_Reset,
    output logic               line_Start,
    output logic [COORD_W-1:0] line_x0,
    output logic [COORD_W-1:0] line_y0,
    output logic [COORD_W-1:0] line_x1,
    output logic [COORD_W-1:0] line_y1,
    input  logic               line_Done,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic               pix_we,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color
);

    seq_state_t         state_q;
    edge_idx_t          edge_q;
    logic [COORD_W-1:0] vx_q [3];
    logic [COORD_W-1:0] vy_q [3];
    logic [COLOR_W-1:0] color_q;
    logic               ready_q, load_q, run_q, done_q;
    logic [1:0]         a_idx, b_idx;

`ifdef BACKFACE_CULL_EN
    localparam int AREA_W = 2 * COORD_W + 2;
    logic signed [AREA_W-1:0] area_q;
    logic                     culled_q;
    logic                     accept;

    // The area is registered on the accept edge from the live inputs, so it
    // is already valid during the single AREA cycle.
    assign accept = (state_q == S_IDLE) && tri_valid;

    tri_signed_area #(.AREA_W(AREA_W)) u_area (
        .Clk    (Clk),
        .Reset  (Reset),
        .en_i   (accept),
        .p0_i   ({v0x, v0y}),
        .p1_i   ({v1x, v1y}),
        .p2_i   ({v2x, v2y}),
        .area_o (area_q)
    );

    assign tri_culled = culled_q;
`else
    assign tri_culled = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            edge_q  <= '0;
            ready_q <= 1'b1;
            load_q  <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            color_q <= '0;
            for (int i = 0; i < 3; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
`ifdef BACKFACE_CULL_EN
            culled_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef BACKFACE_CULL_EN
            culled_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (tri_valid) begin
                        vx_q[0] <= v0x;
                        vy_q[0] <= v0y;
                        vx_q[1] <= v1x;
                        vy_q[1] <= v1y;
                        vx_q[2] <= v2x;
                        vy_q[2] <= v2y;
                        color_q <= tri_color;
                        edge_q  <= '0;
                        ready_q <= 1'b0;
`ifdef BACKFACE_CULL_EN
                        state_q <= S_AREA;
`else
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
`endif
                    end
                end
`ifdef BACKFACE_CULL_EN
                S_AREA: begin
                    if (area_q[AREA_W-1] || (area_q == '0)) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        culled_q <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                    end
                end
`endif
                S_LOAD: begin
                    state_q <= S_RUN;
                    load_q  <= 1'b0;
                    run_q   <= 1'b1;
                end
                S_RUN: begin
                    if (line_Done) begin
                        state_q <= S_RELEASE;
                        run_q   <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    // Start is already low here, letting the drawer fall back to Wait.
                    if (edge_q == LAST_EDGE) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        edge_q  <= edge_q + 1'b1;
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Edge 0: v0->v1, edge 1: v1->v2, edge 2: v2->v0.
    always_comb begin
        a_idx = 2'd2;
        b_idx = 2'd0;
        case (edge_q)
            2'd0: begin a_idx = 2'd0; b_idx = 2'd1; end
            2'd1: begin a_idx = 2'd1; b_idx = 2'd2; end
            default: ;
        endcase
    end

    assign line_x0    = vx_q[a_idx];
    assign line_y0    = vy_q[a_idx];
    assign line_x1    = vx_q[b_idx];
    assign line_y1    = vy_q[b_idx];

    assign tri_ready  = ready_q;
    assign tri_done   = done_q;
    assign line_Reset = Reset | load_q;
    assign line_Start = run_q;
    assign pix_we     = run_q;
    assign pix_x      = DrawX;
    assign pix_y      = DrawY;
    assign pix_color  = color_q;

endmodule
